// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: UART receiver (8N1, mid-bit sampling) feeding a first-word fall-through byte FIFO.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN.

// Generic synchronous FIFO, first-word fall-through, power-of-two depth.
// Latency: a written entry is visible on rd_dat one clock after the write.
// Backpressure: wr_rdy drops when full unless the head is popped in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_vld,
    output logic                       wr_rdy,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       rd_vld,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    assign rd_vld  = (count != '0);
    assign rd_fire = rd_vld && rd_rdy;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a write then.
    assign wr_rdy  = (count != CW'(DEPTH)) || rd_fire;
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_fire) - CW'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_dat;
    end
endmodule

// UART receive front end: synchroniser, deframer FSM, byte FIFO and sticky error flags.
// Latency: stop-bit sample to o_valid is one clock (~9.5 bit times + 3 clocks from start edge).
// Backpressure: none toward the line; a byte arriving at a full FIFO is dropped and flags o_overrun.
module uart_rx_buffered #(
    parameter int CLK_HZ     = 16_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            uart_rx_unsafe,
    output logic [7:0]                      o_data,
    output logic                            o_valid,
    input  logic                            i_read,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
    output logic                            o_overrun,
    output logic                            o_frame_err,
    output logic                            o_parity_err,
    input  logic                            i_clear_err
);
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int HALF    = BIT_CYC / 2;
    localparam int TW      = $clog2(BIT_CYC);
    localparam logic [TW-1:0] BIT_M1  = TW'(BIT_CYC - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    sync;
    logic          rx_s;
    logic [TW-1:0] timer;
    logic          tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          shift_en;
    logic          push;
    logic          frame_set;
    logic          overrun_set;
    logic          fifo_rdy;
`ifdef UART_RX_PARITY_EN
    logic          parity_set;
    logic          par_bad;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync <= 2'b11;
        else          sync <= {sync[0], uart_rx_unsafe};
    end
    assign rx_s = sync[1];
    assign tick = (timer == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!rx_s) state_nxt = S_START;
            S_START:  if (tick) state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                          state_nxt = S_PARITY;
`else
                          state_nxt = S_STOP;
`endif
                      end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (tick) state_nxt = S_STOP;
`endif
            // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start edge.
            S_STOP:   if (tick) state_nxt = rx_s ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx_s) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        shift_en  = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_set = 1'b0;
`endif
        case (state)
            S_DATA:   shift_en = tick;
`ifdef UART_RX_PARITY_EN
            S_PARITY: parity_set = tick && (^{shreg, rx_s});
            S_STOP: begin
                push      = tick && rx_s && !par_bad;
                frame_set = tick && !rx_s;
            end
`else
            S_STOP: begin
                push      = tick && rx_s;
                frame_set = tick && !rx_s;
            end
`endif
            default: ;
        endcase
    end

    // Timer free-runs in IDLE/BREAK; its value only matters after a reload on state entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state_nxt != state || tick)
                timer <= (state_nxt == S_START) ? HALF_M1 : BIT_M1;
            else
                timer <= timer - TW'(1);
            if (state_nxt == S_DATA && state != S_DATA) bit_idx <= '0;
            else if (shift_en)                          bit_idx <= bit_idx + 3'd1;
            if (shift_en) shreg <= {rx_s, shreg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                par_bad <= 1'b0;
        else if (state_nxt == S_DATA && state != S_DATA) par_bad <= 1'b0;
        else if (parity_set)                         par_bad <= 1'b1;
    end
`endif

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .wr_vld (push),
        .wr_rdy (fifo_rdy),
        .wr_dat (shreg),
        .rd_vld (o_valid),
        .rd_rdy (i_read),
        .rd_dat (o_data),
        .count  (o_count)
    );

    assign overrun_set = push && !fifo_rdy;

    // Set terms are OR-ed after the clear so a same-cycle event is never lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_overrun   <= overrun_set | (o_overrun & ~i_clear_err);
            o_frame_err <= frame_set | (o_frame_err & ~i_clear_err);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_parity_err <= 1'b0;
        else          o_parity_err <= parity_set | (o_parity_err & ~i_clear_err);
    end
`else
    assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Randomised bench for uart_rx_buffered: frame-level reference model with an output scoreboard.
module tb_uart_rx_buffered;
    localparam int CLK_HZ = 16_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int DEPTH  = 4;
    localparam int BIT    = CLK_HZ / BAUD;
    localparam int HALF   = BIT / 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       rd    = 1'b0;
    logic       clr   = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       ovr;
    logic       ferr;
    logic       perr;

    logic [7:0] exp_q[$];
    bit         exp_ovr  = 1'b0;
    bit         exp_ferr = 1'b0;
    bit         exp_perr = 1'b0;
    bit         rd_en    = 1'b0;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .uart_rx_unsafe (rx),
        .o_data         (data),
        .o_valid        (valid),
        .i_read         (rd),
        .o_count        (count),
        .o_overrun      (ovr),
        .o_frame_err    (ferr),
        .o_parity_err   (perr),
        .i_clear_err    (clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Frame-level model: a good frame yields its byte unless the unread backlog is already DEPTH.
    task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        if (!par_ok)  exp_perr = 1'b1;
        if (!stop_ok) exp_ferr = 1'b1;
        if (stop_ok && par_ok) begin
            if (!rd_en && exp_q.size() == DEPTH) exp_ovr = 1'b1;
            else exp_q.push_back(d);
        end
    endtask

    task automatic line_bits(input logic b, input int nbits);
        rx = b;
        repeat (nbits * BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        model_frame(d, stop, 1'b1);
        line_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) line_bits(d[i], 1);
`ifdef UART_RX_PARITY_EN
        line_bits(^d, 1);
`endif
        line_bits(stop, 1);
        rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_badpar(input logic [7:0] d);
        model_frame(d, 1'b1, 1'b0);
        line_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) line_bits(d[i], 1);
        line_bits(~(^d), 1);
        line_bits(1'b1, 1);
    endtask
`endif

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
        chk("drain_count", int'(count), 0);
        chk("drain_valid", int'(valid), 0);
    endtask

    task automatic clear_errs();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_overrun"}, int'(ovr), int'(exp_ovr));
        chk({tag, "_frame_err"}, int'(ferr), int'(exp_ferr));
        chk({tag, "_parity_err"}, int'(perr), int'(exp_perr));
    endtask

    // Monitor: pops the scoreboard for every byte the DUT presents while reading is enabled.
    initial begin
        forever begin
            @(negedge clk);
            rd = 1'b0;
            if (rd_en && rst_n && valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data);
                end else begin
                    chk("rx_byte", int'(data), int'(exp_q.pop_front()));
                end
                rd = 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_count", int'(count), 0);
        chk_flags("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte, held then read once
        send_frame(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        chk("t1_valid", int'(valid), 1);
        chk("t1_data", int'(data), int'(exp_q[0]));
        chk("t1_count", int'(count), exp_q.size());
        rd_en = 1'b1;
        wait_drain();

        // Short glitch is ignored
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("t2_valid", int'(valid), 0);
        chk_flags("t2");
        send_frame(8'h3C, 1'b1);
        wait_drain();

        // Framing error, break, recovery
        send_frame(8'h3C, 1'b0);
        line_bits(1'b0, 3);
        line_bits(1'b1, 1);
        send_frame(8'h11, 1'b1);
        wait_drain();
        chk_flags("t3");
        clear_errs();
        chk_flags("t3_clr");

        // Overrun with reads held off
        rd_en = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        chk("t4_count", int'(count), exp_q.size());
        chk("t4_head", int'(data), int'(exp_q[0]));
        chk_flags("t4");
        rd_en = 1'b1;
        wait_drain();
        clear_errs();

        // Reset during data bit 3 of 0xFF
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT + HALF) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        @(negedge clk);
        chk("t5_valid", int'(valid), 0);
        chk("t5_data", int'(data), 0);
        chk("t5_count", int'(count), 0);
        chk_flags("t5");
        repeat (8 * BIT) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h42, 1'b1);
        wait_drain();

`ifdef UART_RX_PARITY_EN
        send_frame_badpar(8'h07);
        wait_drain();
        chk_flags("t6_bad");
        send_frame(8'h07, 1'b1);
        wait_drain();
        chk_flags("t6_good");
        clear_errs();
`endif

        // Randomised traffic with occasional glitches and framing errors
        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if ($urandom_range(3) == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(HALF - 2, 1)) @(negedge clk);
                rx = 1'b1;
                repeat (2 * BIT) @(negedge clk);
            end
            if ($urandom_range(7) == 0) begin
                send_frame(d, 1'b0);
                line_bits(1'b0, 2);
                line_bits(1'b1, 1);
            end else begin
                send_frame(d, 1'b1);
            end
            repeat ($urandom_range(2) * BIT) @(negedge clk);
        end
        wait_drain();
        chk_flags("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
